// File: rtl/receiver_pkg.sv
// receiver_pkg: shared widths, sample types and sign-magnitude conversion for the receiver.
package receiver_pkg;
    localparam int WIDTH  = 16;
    localparam int TAPS   = 4;
    localparam int NUM_CH = 4;
    localparam int ACC_W  = WIDTH + $clog2(TAPS);

    typedef logic signed [WIDTH-1:0] sample_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Negative zero naturally maps to 0 because -0 == 0.
    function automatic sample_t sm_to_tc(input logic [WIDTH-1:0] x);
        sample_t mag;
        mag = sample_t'({1'b0, x[WIDTH-2:0]});
        return x[WIDTH-1] ? -mag : mag;
    endfunction
endpackage

// File: rtl/rx_channel.sv
// rx_channel: one channel -- sign-magnitude to two's complement, TAPS-deep moving average.
module rx_channel
    import receiver_pkg::*;
#(
    parameter int WIDTH = receiver_pkg::WIDTH,
    parameter int TAPS  = receiver_pkg::TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);
    localparam int SH = $clog2(TAPS);
    localparam int AW = WIDTH + SH;

    logic signed [WIDTH-1:0] s1_d, s1_q, out_d, out_q;
    logic signed [WIDTH-1:0] win_d [TAPS];
    logic signed [WIDTH-1:0] hist_d [TAPS-1];
    logic signed [WIDTH-1:0] hist_q [TAPS-1];
    logic signed [AW-1:0]    acc;

    // The stage-1 register is the newest window entry, so only TAPS-1 older samples are stored.
    always_comb begin
        s1_d     = sm_to_tc(data_in);
        win_d[0] = s1_q;
        for (int i = 1; i < TAPS; i++) win_d[i] = hist_q[i-1];
        for (int i = 0; i < TAPS - 1; i++) hist_d[i] = win_d[i];
        acc = '0;
        for (int i = 0; i < TAPS; i++) acc = acc + AW'(win_d[i]);
        out_d = WIDTH'(acc >>> SH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            hist_q <= '{default: '0};
            out_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            hist_q <= hist_d;
            out_q  <= out_d;
        end
    end

    assign data_out = out_q;
endmodule

// File: rtl/receiver.sv
// receiver: four independent sign-magnitude receive channels, each moving-average filtered.
module receiver
    import receiver_pkg::*;
#(
    parameter int WIDTH = receiver_pkg::WIDTH,
    parameter int TAPS  = receiver_pkg::TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [WIDTH-1:0] data_in3,
    input  logic [WIDTH-1:0] data_in4,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    output logic [WIDTH-1:0] data_out4
);
    rx_channel #(.WIDTH(WIDTH), .TAPS(TAPS)) u_ch1 (.clk(clk), .rst(rst), .data_in(data_in1), .data_out(data_out1));
    rx_channel #(.WIDTH(WIDTH), .TAPS(TAPS)) u_ch2 (.clk(clk), .rst(rst), .data_in(data_in2), .data_out(data_out2));
    rx_channel #(.WIDTH(WIDTH), .TAPS(TAPS)) u_ch3 (.clk(clk), .rst(rst), .data_in(data_in3), .data_out(data_out3));
    rx_channel #(.WIDTH(WIDTH), .TAPS(TAPS)) u_ch4 (.clk(clk), .rst(rst), .data_in(data_in4), .data_out(data_out4));
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed vectors; driver queues hand-computed outputs, monitor checks each edge.
module tb_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in1 = '0, data_in2 = '0, data_in3 = '0, data_in4 = '0;
    logic [15:0] data_out1, data_out2, data_out3, data_out4;

    typedef struct {
        string            name;
        logic [3:0]       mask;
        logic [3:0][15:0] e;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 1'b0;

    receiver dut (
        .clk(clk), .rst(rst),
        .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .data_in4(data_in4),
        .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3), .data_out4(data_out4)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the queued entry is the output expected after the next rising edge.
    task automatic step(input logic r, input logic [15:0] a, b, c, d,
                        input logic [3:0] m, input logic [15:0] e1, e2, e3, e4, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; data_in1 = a; data_in2 = b; data_in3 = c; data_in4 = d;
        x.name = nm; x.mask = m; x.e = {e4, e3, e2, e1};
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        logic [3:0][15:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x   = exp_q.pop_front();
                got = {data_out4, data_out3, data_out2, data_out1};
                for (int i = 0; i < 4; i++) begin
                    if (x.mask[i]) begin
                        n_cmp++;
                        if (got[i] !== x.e[i]) begin
                            n_bad++;
                            $display("FAIL %s ch%0d: got 0x%04h expected 0x%04h", x.name, i + 1, got[i], x.e[i]);
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        step(1, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0, "reset0");
        step(1, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0, "reset1");
        // Ramp from zero history: small positive, 0xAEF1 (-12017), negative zero.
        step(0, 16'h0001, 16'hAEF1, 16'h0001, 16'h8000, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0, "ramp1");
        step(0, 16'h0001, 16'hAEF1, 16'h0001, 16'h8000, 4'hF, 16'h0, 16'hF443, 16'h0, 16'h0, "ramp2");
        step(0, 16'h0001, 16'hAEF1, 16'h0001, 16'h8000, 4'hF, 16'h0, 16'hE887, 16'h0, 16'h0, "ramp3");
        step(0, 16'h0001, 16'hAEF1, 16'h0001, 16'h8000, 4'hF, 16'h0, 16'hDCCB, 16'h0, 16'h0, "ramp4");
        step(0, 16'h0001, 16'hAEF1, 16'h0001, 16'h8000, 4'hF, 16'h1, 16'hD10F, 16'h1, 16'h0, "ramp5");
        step(0, 16'h0001, 16'hAEF1, 16'h0001, 16'h8000, 4'hF, 16'h1, 16'hD10F, 16'h1, 16'h0, "ramp6");
        for (int k = 0; k < 4; k++)
            step(0, 16'h0012, 16'h0024, 16'h0046, 16'h008D, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, "fill");
        step(0, 16'h0012, 16'h0024, 16'h0046, 16'h008D, 4'hF, 16'd18, 16'd36, 16'd70, 16'd141, "const");
        step(0, 16'h0012, 16'h0024, 16'h0046, 16'h008D, 4'hF, 16'd18, 16'd36, 16'd70, 16'd141, "const_hold");
        for (int k = 0; k < 4; k++)
            step(0, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h3FF4, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, "fill");
        step(0, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h3FF4, 4'hF, 16'h0, 16'h7FFF, 16'h8001, 16'd16372, "extremes");
        for (int k = 0; k < 8; k++) begin
            logic [15:0] p, n;
            p = k[0] ? 16'hFFFF : 16'h7FFF;
            n = k[0] ? 16'h7FFF : 16'hFFFF;
            step(0, p, p, n, p, (k >= 4) ? 4'hF : 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, "alternate");
        end
        step(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, "pre_rst");
        step(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, "pre_rst");
        step(1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0, "mid_rst");
        step(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'hF, 16'h0, 16'h0, 16'h0, 16'h0, "rerampa");
        step(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'hF, 16'h40, 16'h40, 16'h40, 16'h40, "rerampb");
        step(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'hF, 16'h80, 16'h80, 16'h80, 16'h80, "rerampc");
        step(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'hF, 16'hC0, 16'hC0, 16'hC0, 16'hC0, "rerampd");
        step(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'hF, 16'h100, 16'h100, 16'h100, 16'h100, "rerampe");
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 data_in1..data_in4  input  16 each  per-channel received sample, sign-magnitude: bit15 = sign (1 = negative), bits14:0 = magnitude.
REQ-005 data_out1..data_out4  output  16 each  per-channel filtered sample, two's complement, registered.
REQ-006 Parameters SHALL be WIDTH, default 16, sample width in bits; and TAPS, default 4, moving-average length (power of two).

Function
REQ-007 Channels SHALL be identical and fully independent; channel n maps data_inN to data_outN only.
REQ-008 Stage 1 SHALL register each input converted to two's complement:
- sign=0 -> +magnitude.
- sign=1 -> -magnitude.
- 0x8000 (negative zero) -> 0.
REQ-009 Stage 2 SHALL keep a per-channel window of the last TAPS converted samples.
REQ-010 The window SHALL be summed at WIDTH+log2(TAPS) = 18 bits, signed, with no overflow possible.
REQ-011 Output SHALL be the window sum arithmetic-shifted right by log2(TAPS): truncation toward negative infinity, e.g. -3004.25 -> -3005.
REQ-012 No saturation logic is needed: the result always lies within [-32767, +32767].
REQ-013 Latency: a sample present at rising edge k SHALL first contribute to data_outN after edge k+1.
REQ-014 The sample at edge k SHALL stop contributing after edge k+TAPS.
REQ-015 A constant input held for TAPS+1 or more cycles SHALL produce an output equal to its two's-complement value.
REQ-016 There is no handshake: a new sample SHALL be accepted on every clock edge.
REQ-017 Arithmetic SHALL be signed throughout; the window SHALL not wrap or overflow for any input code.

Reset
REQ-018 While rst=1 at a rising edge, the following SHALL clear to 0: stage-1 registers, all window entries, sums, and data_out1..4.
REQ-019 After rst is released, the window SHALL fill from zeros: outputs ramp over the first TAPS samples.
REQ-020 Reset asserted mid-stream SHALL discard all history on that edge.

Structure
REQ-021 Package receiver_pkg SHALL hold:
- WIDTH, TAPS, NUM_CH=4.
- typedef sample_t (logic signed [WIDTH-1:0]).
- typedef acc_t (18-bit signed).
- function sm_to_tc (sign-magnitude to two's complement).
REQ-022 Sub-module rx_channel SHALL implement one channel (conversion, window, sum, shift).
REQ-023 receiver SHALL instantiate rx_channel four times.

Verification
REQ-024 Reset, then data_in1..4=0x0001 held -> data_out=0x0000, 0x0000, 0x0000, then 0x0001 from the 4th output cycle onward.
REQ-025 Inputs 0x0012/0x0024/0x0046/0x008D held 5+ cycles -> outputs 18/36/70/141.
REQ-026 Reset, then data_in1=0xAEF1 held -> data_out1 ramp -3005, -6009, -9013, then -12017 (0xD10F) steady.
REQ-027 data_in4=0x3FF4 held -> data_out4=16372; input 0x8000 held -> output 0.
REQ-028 Alternate 0x7FFF / 0xFFFF every cycle -> steady output 0 once the window is full.
REQ-029 Assert rst for one cycle during a ramp -> all outputs 0 on the next edge, then the ramp restarts from zero history.
